// File: rtl/ahb_slave_pkg.sv
// Shared constants, state encoding and small helpers for the AHB-lite register-bank slave.
package ahb_slave_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic RESP_OKAY  = 1'b0;
    localparam logic RESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAIT = 3'd1,
        DONE = 3'd2,
        ERR1 = 3'd3,
        ERR2 = 3'd4
    } state_e;

    // hready as seen on the bus while the FSM sits in state s
    function automatic logic state_ready(input state_e s);
        logic r;
        case (s)
            IDLE, DONE, ERR2: r = 1'b1;
            WAIT, ERR1:       r = 1'b0;
            default:          r = 1'b1;
        endcase
        return r;
    endfunction

    // hresp as seen on the bus while the FSM sits in state s
    function automatic logic state_resp(input state_e s);
        logic r;
        case (s)
            ERR1, ERR2: r = RESP_ERROR;
            default:    r = RESP_OKAY;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ahb_addr_decode.sv
// Combinational address decode: checks haddr against the runtime base address and
// yields the register index of a valid word access.
module ahb_addr_decode #(
    parameter int AW    = 16,
    parameter int DEPTH = 8,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic [AW-1:0] haddr_i,
    input  logic [AW-1:0] sadd_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o
);

    logic [AW-1:0] off_s;
    logic          above_s;
    logic          aligned_s;
    logic          in_range_s;

    // Offset from base; DEPTH is a power of two, so "word offset < DEPTH" means
    // every bit above the index field is zero.
    always_comb begin
        off_s      = haddr_i - sadd_i;
        above_s    = (haddr_i >= sadd_i);
        aligned_s  = (off_s[1:0] == 2'b00);
        in_range_s = (off_s[AW-1:IW+2] == '0);
        valid_o    = above_s & aligned_s & in_range_s;
        idx_o      = off_s[IW+1:2];
    end

endmodule

// File: rtl/ahb_slave_regbank.sv
// AHB-lite slave with a DEPTH-word register bank, runtime base address,
// WAIT_STATES wait cycles per OKAY transfer and a two-cycle ERROR response.
module ahb_slave_regbank
    import ahb_slave_pkg::*;
#(
    parameter int AW          = 16,
    parameter int DW          = 32,
    parameter int DEPTH       = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hsel,
    input  logic [AW-1:0] haddr,
    input  logic [1:0]    htrans,
    input  logic          hwrite,
    input  logic [DW-1:0] hwdata,
    input  logic [AW-1:0] sadd,
    output logic [DW-1:0] hrdata,
    output logic          hready,
    output logic          hresp
);

    localparam int         IW      = $clog2(DEPTH);
    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          write_q, write_d;
    logic          hready_q, hready_d;
    logic          hresp_q, hresp_d;
    logic [DW-1:0] hrdata_q, hrdata_d;
    logic [DW-1:0] regs_q [DEPTH];

    logic          dec_valid_s;
    logic [IW-1:0] dec_idx_s;
    logic          accept_s;
    logic          wr_en_s;
    logic          rd_load_s;
    logic          fwd_s;

    ahb_addr_decode #(
        .AW    (AW),
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_decode (
        .haddr_i (haddr),
        .sadd_i  (sadd),
        .valid_o (dec_valid_s),
        .idx_o   (dec_idx_s)
    );

    assign accept_s = hsel & ((htrans == HTRANS_NONSEQ) | (htrans == HTRANS_SEQ)) & hready_q;
    assign wr_en_s  = (state_q == DONE) & write_q;

    // Next-state logic: latch the decode on accept, count wait cycles, sequence errors.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        write_d = write_q;
        case (state_q)
            IDLE, DONE, ERR2: begin
                if (accept_s) begin
                    idx_d   = dec_idx_s;
                    write_d = hwrite;
                    if (!dec_valid_s) begin
                        state_d = ERR1;
                    end else if (WAIT_STATES == 0) begin
                        state_d = DONE;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WS_LOAD;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ERR1: begin
                state_d = ERR2;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        hready_d = state_ready(state_d);
        hresp_d  = state_resp(state_d);
    end

    // Read data for the upcoming DONE cycle; a write completing on the same edge to
    // the same word is forwarded so back-to-back read-after-write sees the new value.
    always_comb begin
        rd_load_s = (state_d == DONE) & ~write_d;
        fwd_s     = wr_en_s & (idx_q == idx_d);
        hrdata_d  = hrdata_q;
        if (rd_load_s) begin
            if (fwd_s) begin
                hrdata_d = hwdata;
            end else begin
                hrdata_d = regs_q[idx_d];
            end
        end else begin
            hrdata_d = hrdata_q;
        end
    end

    // Control and output registers; reset aborts any transfer in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            idx_q    <= '0;
            write_q  <= 1'b0;
            hready_q <= 1'b1;
            hresp_q  <= RESP_OKAY;
            hrdata_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            write_q  <= write_d;
            hready_q <= hready_d;
            hresp_q  <= hresp_d;
            hrdata_q <= hrdata_d;
        end
    end

    // Register bank: written only at the end of a write DONE cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en_s) begin
            regs_q[idx_q] <= hwdata;
        end
    end

    assign hrdata = hrdata_q;
    assign hready = hready_q;
    assign hresp  = hresp_q;

endmodule

// File: tb/tb_ahb_slave_regbank.sv
// Directed self-checking bench: one instance with one wait state, one with none.
module tb_ahb_slave_regbank;

    localparam int AW = 16;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          hsel0, hsel1;
    logic [AW-1:0] haddr;
    logic [1:0]    htrans;
    logic          hwrite;
    logic [DW-1:0] hwdata;
    logic [AW-1:0] sadd;
    logic [DW-1:0] hrdata0, hrdata1;
    logic          hready0, hready1;
    logic          hresp0, hresp1;

    int n_checks = 0;
    int n_fail   = 0;
    int cur      = 1;

    logic [DW-1:0] m_rdata;
    logic          m_ready;
    logic          m_resp;

    assign m_rdata = (cur == 1) ? hrdata1 : hrdata0;
    assign m_ready = (cur == 1) ? hready1 : hready0;
    assign m_resp  = (cur == 1) ? hresp1  : hresp0;

    ahb_slave_regbank #(.AW(AW), .DW(DW), .DEPTH(8), .WAIT_STATES(1)) dut1 (
        .clk(clk), .rst(rst), .hsel(hsel1), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hwdata(hwdata), .sadd(sadd),
        .hrdata(hrdata1), .hready(hready1), .hresp(hresp1)
    );

    ahb_slave_regbank #(.AW(AW), .DW(DW), .DEPTH(8), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hwdata(hwdata), .sadd(sadd),
        .hrdata(hrdata0), .hready(hready0), .hresp(hresp0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Single transfer on the selected instance; called at posedge+1 with the slave idle.
    task automatic xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        output logic [DW-1:0] rdata, output int waits,
                        output logic resp_first, output logic resp_last);
        bit done;
        hsel0  = (cur == 0);
        hsel1  = (cur == 1);
        haddr  = addr;
        htrans = 2'b10;
        hwrite = wr;
        @(posedge clk); #1;
        hsel0  = 1'b0;
        hsel1  = 1'b0;
        htrans = 2'b00;
        hwdata = data;
        waits = 0; resp_first = 1'b0; resp_last = 1'b0; rdata = '0; done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (m_ready === 1'b1) begin
                done      = 1'b1;
                rdata     = m_rdata;
                resp_last = m_resp;
            end else begin
                if (waits == 0) resp_first = m_resp;
                waits++;
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL xfer_timeout addr=%h: hready never returned high within 20 cycles", addr);
        end
    endtask

    // Back-to-back write then read on the zero-wait instance.
    task automatic b2b(input logic [AW-1:0] waddr, input logic [DW-1:0] wdata, input logic [AW-1:0] raddr,
                       output logic rdy_w, output logic rdy_r, output logic resp_r, output logic [DW-1:0] rdata);
        hsel0  = 1'b1;
        haddr  = waddr;
        htrans = 2'b10;
        hwrite = 1'b1;
        @(posedge clk); #1;
        hwdata = wdata;
        haddr  = raddr;
        hwrite = 1'b0;
        htrans = 2'b11;
        @(negedge clk);
        rdy_w = hready0;
        @(posedge clk); #1;
        hsel0  = 1'b0;
        htrans = 2'b00;
        @(negedge clk);
        rdy_r  = hready0;
        resp_r = hresp0;
        rdata  = hrdata0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; hsel0 = 1'b0; hsel1 = 1'b0; haddr = '0; htrans = 2'b00;
        hwrite = 1'b0; hwdata = '0; sadd = 16'h0008;
        #2 rst = 1'b0;
        #1;
        n_checks++; if (hready1 !== 1'b1) begin n_fail++; $display("FAIL reset_hready1 got %b exp 1", hready1); end
        n_checks++; if (hresp1 !== 1'b0) begin n_fail++; $display("FAIL reset_hresp1 got %b exp 0", hresp1); end
        n_checks++; if (hrdata1 !== 32'h0) begin n_fail++; $display("FAIL reset_hrdata1 got %h exp 0", hrdata1); end
        n_checks++; if (hready0 !== 1'b1) begin n_fail++; $display("FAIL reset_hready0 got %b exp 1", hready0); end
        n_checks++; if (hresp0 !== 1'b0) begin n_fail++; $display("FAIL reset_hresp0 got %b exp 0", hresp0); end
        n_checks++; if (hrdata0 !== 32'h0) begin n_fail++; $display("FAIL reset_hrdata0 got %h exp 0", hrdata0); end
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        logic [DW-1:0] rd; int w; logic rf, rl;
        cur = 1;
        xfer(1'b1, 16'h0008, 32'd20, rd, w, rf, rl);
        n_checks++; if (w !== 1) begin n_fail++; $display("FAIL wr_waits got %0d exp 1", w); end
        n_checks++; if (rf !== 1'b0 || rl !== 1'b0) begin n_fail++; $display("FAIL wr_resp got %b%b exp 00", rf, rl); end
        xfer(1'b0, 16'h0008, 32'd0, rd, w, rf, rl);
        n_checks++; if (rd !== 32'd20) begin n_fail++; $display("FAIL rd_data got %0d exp 20", rd); end
        n_checks++; if (w !== 1) begin n_fail++; $display("FAIL rd_waits got %0d exp 1", w); end
        n_checks++; if (rl !== 1'b0) begin n_fail++; $display("FAIL rd_resp got %b exp 0", rl); end
    endtask

    task automatic test_range();
        logic [DW-1:0] rd; int w; logic rf, rl;
        cur = 1;
        xfer(1'b1, 16'h0024, 32'hDEADBEEF, rd, w, rf, rl);
        n_checks++; if (w !== 1 || rl !== 1'b0) begin n_fail++; $display("FAIL top_wr got waits=%0d resp=%b exp 1/0", w, rl); end
        xfer(1'b0, 16'h0024, 32'h0, rd, w, rf, rl);
        n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL top_rd got %h exp deadbeef", rd); end
        xfer(1'b0, 16'h0028, 32'h0, rd, w, rf, rl);
        n_checks++; if (rf !== 1'b1 || w !== 1) begin n_fail++; $display("FAIL oor_err1 got resp=%b waits=%0d exp 1/1", rf, w); end
        n_checks++; if (rl !== 1'b1) begin n_fail++; $display("FAIL oor_err2 got resp=%b exp 1", rl); end
        n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL oor_hold got %h exp deadbeef", rd); end
        xfer(1'b1, 16'h0028, 32'h00000BAD, rd, w, rf, rl);
        n_checks++; if (rf !== 1'b1 || rl !== 1'b1) begin n_fail++; $display("FAIL oor_wr_resp got %b%b exp 11", rf, rl); end
        xfer(1'b0, 16'h0024, 32'h0, rd, w, rf, rl);
        n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL oor_keep7 got %h exp deadbeef", rd); end
        xfer(1'b0, 16'h0008, 32'h0, rd, w, rf, rl);
        n_checks++; if (rd !== 32'd20) begin n_fail++; $display("FAIL oor_keep0 got %h exp 14", rd); end
    endtask

    task automatic test_misaligned();
        logic [DW-1:0] rd; int w; logic rf, rl;
        cur = 1;
        xfer(1'b1, 16'h000A, 32'h0000FFFF, rd, w, rf, rl);
        n_checks++; if (rf !== 1'b1 || rl !== 1'b1 || w !== 1) begin n_fail++; $display("FAIL misalign got %b%b waits=%0d exp 11/1", rf, rl, w); end
        xfer(1'b1, 16'h0004, 32'h0000EEEE, rd, w, rf, rl);
        n_checks++; if (rf !== 1'b1 || rl !== 1'b1 || w !== 1) begin n_fail++; $display("FAIL below_base got %b%b waits=%0d exp 11/1", rf, rl, w); end
        xfer(1'b0, 16'h0008, 32'h0, rd, w, rf, rl);
        n_checks++; if (rd !== 32'd20) begin n_fail++; $display("FAIL err_keep0 got %h exp 14", rd); end
        xfer(1'b0, 16'h0024, 32'h0, rd, w, rf, rl);
        n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL err_keep7 got %h exp deadbeef", rd); end
    endtask

    task automatic test_back_to_back();
        logic rw, rr, rsp; logic [DW-1:0] rd; int w; logic rf, rl;
        cur = 0;
        b2b(16'h0010, 32'h55, 16'h0010, rw, rr, rsp, rd);
        n_checks++; if (rw !== 1'b1 || rr !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got %b%b exp 11", rw, rr); end
        n_checks++; if (rsp !== 1'b0) begin n_fail++; $display("FAIL b2b_resp got %b exp 0", rsp); end
        n_checks++; if (rd !== 32'h55) begin n_fail++; $display("FAIL b2b_raw got %h exp 55", rd); end
        xfer(1'b0, 16'h0010, 32'h0, rd, w, rf, rl);
        n_checks++; if (rd !== 32'h55 || w !== 0) begin n_fail++; $display("FAIL ws0_rd got %h waits=%0d exp 55/0", rd, w); end
        b2b(16'h0010, 32'h66, 16'h0014, rw, rr, rsp, rd);
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL b2b_other got %h exp 0", rd); end
        xfer(1'b0, 16'h0010, 32'h0, rd, w, rf, rl);
        n_checks++; if (rd !== 32'h66) begin n_fail++; $display("FAIL b2b_wr2 got %h exp 66", rd); end
    endtask

    task automatic test_reset_midxfer();
        logic [DW-1:0] rd; int w; logic rf, rl;
        cur = 1;
        hsel1 = 1'b1; haddr = 16'h0014; htrans = 2'b10; hwrite = 1'b1;
        @(posedge clk); #1;
        hsel1 = 1'b0; htrans = 2'b00; hwdata = 32'h1234;
        @(negedge clk);
        n_checks++; if (hready1 !== 1'b0) begin n_fail++; $display("FAIL mid_wait got hready=%b exp 0", hready1); end
        #1 rst = 1'b0;
        #1;
        n_checks++; if (hready1 !== 1'b1 || hresp1 !== 1'b0) begin n_fail++; $display("FAIL mid_rst got %b%b exp 10", hready1, hresp1); end
        n_checks++; if (hrdata1 !== 32'h0) begin n_fail++; $display("FAIL mid_rst_data got %h exp 0", hrdata1); end
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        xfer(1'b0, 16'h0014, 32'h0, rd, w, rf, rl);
        n_checks++; if (rd !== 32'h0 || w !== 1 || rl !== 1'b0) begin n_fail++; $display("FAIL mid_idx3 got %h waits=%0d resp=%b exp 0/1/0", rd, w, rl); end
        xfer(1'b0, 16'h0024, 32'h0, rd, w, rf, rl);
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL mid_idx7 got %h exp 0", rd); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_range();
        test_misaligned();
        test_back_to_back();
        test_reset_midxfer();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
